// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg
// Shared constants and types for the direct-mapped data cache controller.
//   TAG_W / IDX_W / OFF_W : address split  tag [31:10], index [9:5], offset [4:0]
//   LINE_W                : line width in bits (8 words of 32 bits)
//   dc_state_e            : controller FSM state, also exported for debug
// ---------------------------------------------------------------------------
package dcache_pkg;

    localparam int TAG_W  = 22;
    localparam int IDX_W  = 5;
    localparam int OFF_W  = 5;
    localparam int LINE_W = 256;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } dc_state_e;

endpackage

// File: rtl/dcache_if.sv
// ---------------------------------------------------------------------------
// dcache_if
// Bundle of the CPU-side and memory-side signals of dcache_controller.
//   master : the environment (CPU MEM stage + backing memory)
//   slave  : the cache controller
//
// Handshakes:
//   CPU side   : cpu_req is held with cpu_we/cpu_addr/cpu_wdata stable while
//                cpu_stall is high; the access completes on the rising edge
//                where cpu_req=1 and cpu_stall=0 (load data valid that cycle).
//   Memory side: mem_req/mem_we/mem_addr/mem_wdata are held stable until a
//                one-cycle mem_ack pulse; mem_ack is ignored while mem_req=0.
// ---------------------------------------------------------------------------
interface dcache_if #(
    parameter int LINE_W = dcache_pkg::LINE_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_array.sv
// ---------------------------------------------------------------------------
// dcache_array
// Tag, valid, dirty and data storage for a direct-mapped cache.
//   rd_idx_i          : combinational read port index
//   rd_*_o            : valid/dirty/tag/line of the indexed entry
//   wr_en_i           : write the entry at wr_idx_i: valid<=1, dirty<=wr_dirty_i,
//                       tag<=wr_tag_i, and every data word whose wr_mask_i bit is set
// Only valid/dirty are reset; tag and data contents are don't-care until valid.
// ---------------------------------------------------------------------------
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int LINE_W    = dcache_pkg::LINE_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [IDX_W-1:0]         rd_idx_i,
    output logic                     rd_valid_o,
    output logic                     rd_dirty_o,
    output logic [TAG_W-1:0]         rd_tag_o,
    output logic [LINE_W-1:0]        rd_data_o,
    input  logic                     wr_en_i,
    input  logic [IDX_W-1:0]         wr_idx_i,
    input  logic [LINE_W/WORD_W-1:0] wr_mask_i,
    input  logic [TAG_W-1:0]         wr_tag_i,
    input  logic                     wr_dirty_i,
    input  logic [LINE_W-1:0]        wr_data_i
);
    localparam int WORDS = LINE_W / WORD_W;

    logic              valid_q [NUM_LINES];
    logic              dirty_q [NUM_LINES];
    logic [TAG_W-1:0]  tag_q   [NUM_LINES];
    logic [LINE_W-1:0] data_q  [NUM_LINES];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            dirty_q[wr_idx_i] <= wr_dirty_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
            for (int w = 0; w < WORDS; w++) begin
                if (wr_mask_i[w]) begin
                    data_q[wr_idx_i][w*WORD_W +: WORD_W] <= wr_data_i[w*WORD_W +: WORD_W];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// ---------------------------------------------------------------------------
// dcache_controller
// Direct-mapped, write-back, write-allocate data cache for a 5-stage pipeline.
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   cpu_req_i/we/addr/wdata: MEM-stage access (held stable while stalled)
//   cpu_rdata_o            : load data on a hit in IDLE, else 0
//   cpu_stall_o            : pipeline freeze while a miss is being serviced
//   mem_req_o/we/addr/wdata: line writeback (we=1) or refill (we=0) request
//   mem_rdata_i, mem_ack_i : refill line and one-cycle completion pulse
//   dbg_state_o            : current FSM state
// A miss retires through IDLE again: after the refill ack the held access
// simply hits, so loads and stores share one completion path.
// ---------------------------------------------------------------------------
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int LINE_W    = dcache_pkg::LINE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output dc_state_e         dbg_state_o
);
    localparam int WORDS = LINE_W / WORD_W;

    dc_state_e         state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [2:0]        req_word;
    logic              unused_addr_bits;

    logic              rd_valid, rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_data;

    logic              wr_en, wr_dirty;
    logic [IDX_W-1:0]  wr_idx;
    logic [WORDS-1:0]  wr_mask;
    logic [TAG_W-1:0]  wr_tag;
    logic [LINE_W-1:0] wr_data;

    logic              hit, ack;

    assign req_tag          = cpu_addr_i[OFF_W+IDX_W +: TAG_W];
    assign req_idx          = cpu_addr_i[OFF_W +: IDX_W];
    assign req_word         = cpu_addr_i[4:2];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    dcache_array #(.NUM_LINES(NUM_LINES), .LINE_W(LINE_W)) u_array (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_idx_i   (req_idx),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_idx_i   (wr_idx),
        .wr_mask_i  (wr_mask),
        .wr_tag_i   (wr_tag),
        .wr_dirty_i (wr_dirty),
        .wr_data_i  (wr_data)
    );

    assign hit = cpu_req_i & rd_valid & (rd_tag == req_tag);
    // An ack only means something while a request is outstanding.
    assign ack = mem_ack_i & mem_req_q;

    // The output gating on rst_i keeps the CPU side quiet during reset even
    // if cpu_req_i is high (valid bits are already cleared, so hit is 0).
    assign cpu_rdata_o = (!rst_i && state_q == ST_IDLE && hit) ? rd_data[req_word*WORD_W +: WORD_W] : 32'd0;
    assign cpu_stall_o = !rst_i && ((state_q != ST_IDLE) || (cpu_req_i && !hit));

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign dbg_state_o = state_q;

    // Single array write port: a store hit updates one word and marks the
    // line dirty; a refill ack installs the whole line clean.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = req_idx;
        wr_mask  = '0;
        wr_tag   = req_tag;
        wr_dirty = 1'b0;
        wr_data  = '0;
        if (state_q == ST_IDLE && hit && cpu_we_i) begin
            wr_en             = 1'b1;
            wr_mask[req_word] = 1'b1;
            wr_dirty          = 1'b1;
            wr_data           = {WORDS{cpu_wdata_i}};
        end else if (state_q == ST_REFILL && ack) begin
            wr_en    = 1'b1;
            wr_idx   = miss_idx_q;
            wr_mask  = '1;
            wr_tag   = miss_tag_q;
            wr_data  = mem_rdata_i;
        end
    end

    // Next-state and registered memory-side outputs. The miss address is
    // captured so the sequence finishes even if cpu_req_i drops mid-miss.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        miss_tag_d  = miss_tag_q;
        miss_idx_d  = miss_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req_i && !hit) begin
                    miss_tag_d = req_tag;
                    miss_idx_d = req_idx;
                    mem_req_d  = 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_d     = ST_WRITEBACK;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {rd_tag, req_idx, {OFF_W{1'b0}}};
                        mem_wdata_d = rd_data;
                    end else begin
                        state_d    = ST_REFILL;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
                    end
                end
            end
            ST_WRITEBACK: begin
                if (ack) begin
                    state_d    = ST_REFILL;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
                end
            end
            ST_REFILL: begin
                if (ack) begin
                    state_d     = ST_IDLE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            miss_tag_q  <= '0;
            miss_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            miss_tag_q  <= miss_tag_d;
            miss_idx_q  <= miss_idx_d;
        end
    end

endmodule
